lap_memory_ctrl: RTL and testbench

Sequencer for the stopwatch lap-record memory. Captures the running time into a DEPTH-entry circular lap buffer on a save request, wipes the buffer on a clear request, and hands lap records to the LCD writer over a valid/ready handshake, including scroll-through of stored laps. Sits between the stopwatch control FSM (SAVE/CLEAR states issue `save_req` / `clear_req`) and the LCD writer. Its `busy` output is the FSM's busy stimulus for those states.

---
 rtl/lap_memory_ctrl.sv | 120 ++++++++++++
 tb/tb_lap_memory_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_memory_ctrl.sv
// lap_memory_ctrl: circular lap-record buffer sequencing save/clear/scroll requests
// and presenting the selected lap to the LCD writer over a valid/ready handshake.
module lap_memory_ctrl #(
  parameter int DEPTH = 8,
  parameter int TIME_W = 24,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              save_req_i,
  input  logic              clear_req_i,
  input  logic              scroll_i,
  input  logic [TIME_W-1:0] time_in_i,
  input  logic              lcd_ready_i,
  output logic              lcd_valid_o,
  output logic [TIME_W-1:0] lcd_data_o,
  output logic [AW-1:0]     lcd_index_o,
  output logic [AW:0]       count_o,
  output logic              full_o,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, WRITE, SHOW, CLR} state_t;
  localparam logic [AW-1:0] ONE = AW'(1);
  localparam logic [AW:0] CONE = (AW+1)'(1);
  state_t state_q, state_d;
  logic [TIME_W-1:0] mem_q [DEPTH];
  logic [TIME_W-1:0] hold_q, hold_d, wd;
  logic [AW-1:0] wp_q, wp_d, k_q, k_d, cc_q, cc_d, wa;
  logic [AW:0] count_q, count_d;
  logic sp_q, sp_d, cp_q, cp_d, we;
  assign lcd_valid_o = state_q == SHOW;
  assign lcd_data_o = lcd_valid_o ? mem_q[wp_q - k_q - ONE] : '0;
  assign lcd_index_o = k_q;
  assign count_o = count_q;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign busy_o = state_q != IDLE || sp_q || cp_q;
  always_comb begin
    state_d = state_q;
    wp_d = wp_q;
    k_d = k_q;
    count_d = count_q;
    hold_d = hold_q;
    sp_d = sp_q;
    cp_d = cp_q;
    cc_d = cc_q;
    we = 1'b0;
    wa = wp_q;
    wd = hold_q;
    // busy-time requests: clear cancels any pending save; the save's time is captured now
    if (state_q != IDLE) begin
      if (clear_req_i) begin
        cp_d = 1'b1;
        sp_d = 1'b0;
      end else if (save_req_i && !cp_q) begin
        sp_d = 1'b1;
        hold_d = time_in_i;
      end
    end
    case (state_q)
      IDLE: begin
        if (clear_req_i || cp_q) begin
          state_d = CLR;
          cc_d = '0;
          cp_d = 1'b0;
          sp_d = 1'b0;
        end else if (save_req_i || sp_q) begin
          state_d = WRITE;
          sp_d = 1'b0;
          hold_d = save_req_i ? time_in_i : hold_q;
        end else if (scroll_i && count_q != '0) begin
          state_d = SHOW;
          k_d = ({1'b0, k_q} + CONE == count_q) ? '0 : k_q + ONE;
        end
      end
      WRITE: begin
        we = 1'b1;
        wp_d = wp_q + ONE;
        count_d = full_o ? count_q : count_q + CONE;
        k_d = '0;
        state_d = SHOW;
      end
      SHOW: state_d = lcd_ready_i ? IDLE : SHOW;
      default: begin
        we = 1'b1;
        wa = cc_q;
        wd = '0;
        cc_d = cc_q + ONE;
        if (cc_q == AW'(DEPTH - 1)) begin
          wp_d = '0;
          count_d = '0;
          k_d = '0;
          state_d = IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clock_i)
    if (we) mem_q[wa] <= wd;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      wp_q <= '0;
      k_q <= '0;
      count_q <= '0;
      hold_q <= '0;
      sp_q <= 1'b0;
      cp_q <= 1'b0;
      cc_q <= '0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      k_q <= k_d;
      count_q <= count_d;
      hold_q <= hold_d;
      sp_q <= sp_d;
      cp_q <= cp_d;
      cc_q <= cc_d;
    end
  end
endmodule

// File: tb/tb_lap_memory_ctrl.sv
// tb_lap_memory_ctrl: scoreboard bench; a newest-first lap list models the buffer and
// predicts every LCD transfer, which a separate monitor checks on each handshake.
module tb_lap_memory_ctrl;
  localparam int DEPTH = 8;
  localparam int TW = 24;
  localparam int AW = 3;
  logic clk = 0, rst = 1;
  logic save_req = 0, clear_req = 0, scroll = 0, lcd_ready = 0;
  logic [TW-1:0] time_in = 0;
  logic lcd_valid, full, busy;
  logic [TW-1:0] lcd_data;
  logic [AW-1:0] lcd_index;
  logic [AW:0] count;
  int total = 0, bad = 0;
  logic rdy_force = 0, rdy_val = 0;
  logic [TW-1:0] laps[$];
  int mk = 0;
  logic [TW-1:0] ed[$];
  int ei[$];

  lap_memory_ctrl #(.DEPTH(DEPTH), .TIME_W(TW)) dut (
    .clock_i(clk), .reset_i(rst), .save_req_i(save_req), .clear_req_i(clear_req),
    .scroll_i(scroll), .time_in_i(time_in), .lcd_ready_i(lcd_ready),
    .lcd_valid_o(lcd_valid), .lcd_data_o(lcd_data), .lcd_index_o(lcd_index),
    .count_o(count), .full_o(full), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic m_save(input logic [TW-1:0] v);
    laps.push_front(v);
    if (laps.size() > DEPTH) void'(laps.pop_back());
    mk = 0;
    ed.push_back(v);
    ei.push_back(0);
  endtask

  task automatic m_scroll();
    if (laps.size() > 0) begin
      mk = (mk + 1 == laps.size()) ? 0 : mk + 1;
      ed.push_back(laps[mk]);
      ei.push_back(mk);
    end
  endtask

  task automatic m_clear();
    laps.delete();
    mk = 0;
  endtask

  task automatic pulse(input int which, input logic [TW-1:0] v);
    if (which == 0) begin
      time_in = v;
      save_req = 1;
    end else if (which == 1) scroll = 1;
    else clear_req = 1;
    @(posedge clk);
    #1;
    save_req = 0;
    scroll = 0;
    clear_req = 0;
    time_in = TW'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || lcd_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy=%0b valid=%0b", busy, lcd_valid);
    end
  endtask

  task automatic chk_occ();
    chk("count", 32'(count), 32'(laps.size()));
    chk("full", 32'(full), 32'(laps.size() == DEPTH));
  endtask

  task automatic do_save(input logic [TW-1:0] v);
    wait_idle();
    m_save(v);
    pulse(0, v);
  endtask

  task automatic do_scroll();
    wait_idle();
    m_scroll();
    pulse(1, '0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    lcd_ready = rdy_force ? rdy_val : 1'($urandom_range(0, 1));
  end

  initial forever begin
    @(negedge clk);
    if (!rst && lcd_valid && lcd_ready) begin
      if (ed.size() == 0) begin
        total++;
        bad++;
        $display("FAIL xfer_unexpected: data=%0h idx=%0d", lcd_data, lcd_index);
      end else begin
        chk("xfer_data", 32'(lcd_data), 32'(ed.pop_front()));
        chk("xfer_idx", 32'(lcd_index), 32'(ei.pop_front()));
      end
    end
  end

  initial begin
    int b;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", 32'(lcd_valid), 0);
    chk("rst_data", 32'(lcd_data), 0);
    chk("rst_index", 32'(lcd_index), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_busy", 32'(busy), 0);

    do_save(24'h000105);
    @(negedge clk);
    chk("write_cycle_valid", 32'(lcd_valid), 0);
    chk("write_cycle_busy", 32'(busy), 1);
    @(negedge clk);
    chk("show_valid_n2", 32'(lcd_valid), 1);
    chk("count_n2", 32'(count), 1);
    do_save(24'h000210);
    do_save(24'h000315);
    wait_idle();
    chk_occ();
    for (int i = 0; i < 3; i++) begin
      do_scroll();
      @(negedge clk);
      chk("scroll_valid_n1", 32'(lcd_valid), 1);
      chk("scroll_index_n1", 32'(lcd_index), 32'(mk));
    end

    wait_idle();
    rdy_force = 1;
    rdy_val = 0;
    m_scroll();
    pulse(1, '0);
    m_save(24'h000500);
    pulse(0, 24'h000500);
    pulse(1, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pend_busy", 32'(busy), 1);
    end
    rdy_force = 0;
    wait_idle();
    chk_occ();

    m_clear();
    pulse(2, '0);
    b = 0;
    @(negedge clk);
    while (busy && b < 50) begin
      b++;
      @(negedge clk);
    end
    chk("clr_cycles", 32'(b), DEPTH);
    chk_occ();

    for (int v = 1; v <= 10; v++) do_save(TW'(v));
    wait_idle();
    chk_occ();
    for (int i = 0; i < 8; i++) do_scroll();

    wait_idle();
    rdy_force = 1;
    rdy_val = 0;
    m_scroll();
    pulse(1, '0);
    m_clear();
    pulse(2, '0);
    pulse(0, 24'h00abcd);
    repeat (2) @(posedge clk);
    #1 rdy_val = 1;
    wait_idle();
    rdy_force = 0;
    chk_occ();
    pulse(1, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("empty_scroll_valid", 32'(lcd_valid), 0);
    end

    do_save(24'h001234);
    wait_idle();
    m_clear();
    pulse(2, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_clr_busy", 32'(busy), 0);
    chk("rst_clr_count", 32'(count), 0);
    chk("rst_clr_valid", 32'(lcd_valid), 0);
    do_save(24'h004242);
    wait_idle();
    chk_occ();

    for (int i = 0; i < 80; i++) begin
      int r = $urandom_range(0, 9);
      if (r == 0) begin
        wait_idle();
        m_clear();
        pulse(2, '0);
      end else if (r < 6) do_save(TW'($urandom));
      else do_scroll();
      wait_idle();
      chk_occ();
    end

    b = 0;
    while (ed.size() > 0 && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (ed.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d transfers missing", ed.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
